// File: rtl/vector_lsu.sv
// rtl/vector_lsu.sv - vector load/store sequencer between datapath and single-port data memory
// Issues one word access per memory handshake; load data collects into per-lane registers.
module vector_lsu #(
  parameter int WIDTH  = 32,
  parameter int NELEM  = 5,
  parameter int STRIDE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_store,
  input  logic [WIDTH-1:0] base_addr,
  input  logic [2:0]       count,
  input  logic [WIDTH-1:0] wd0,
  input  logic [WIDTH-1:0] wd1,
  input  logic [WIDTH-1:0] wd2,
  input  logic [WIDTH-1:0] wd3,
  input  logic [WIDTH-1:0] wd4,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rd0,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  output logic [WIDTH-1:0] rd3,
  output logic [WIDTH-1:0] rd4,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ready
);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t           state, state_next;
  logic             is_store_q;
  logic [WIDTH-1:0] base_q;
  logic [2:0]       n_q;
  logic [2:0]       idx;
  logic [WIDTH-1:0] wd_in [NELEM];
  logic [WIDTH-1:0] wd_q  [NELEM];
  logic [WIDTH-1:0] rd_q  [NELEM];
  logic [2:0]       n_in;
  logic             last_elem;
  logic             xfer;
  logic [WIDTH-1:0] elem_addr;

  assign wd_in[0] = wd0;
  assign wd_in[1] = wd1;
  assign wd_in[2] = wd2;
  assign wd_in[3] = wd3;
  assign wd_in[4] = wd4;

  assign rd0 = rd_q[0];
  assign rd1 = rd_q[1];
  assign rd2 = rd_q[2];
  assign rd3 = rd_q[3];
  assign rd4 = rd_q[4];

  // Counts above the lane count saturate rather than wrap.
  assign n_in      = (count > 3'(NELEM)) ? 3'(NELEM) : count;
  assign xfer      = (state == ISSUE) && mem_ready;
  assign last_elem = (idx == n_q - 3'd1);
  assign elem_addr = base_q + WIDTH'(idx) * WIDTH'(STRIDE);

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state)
      IDLE: begin
        if (start) state_next = (n_in == 3'd0) ? DONE : ISSUE;
      end
      ISSUE: begin
        busy     = 1'b1;
        mem_req  = 1'b1;
        mem_we   = is_store_q;
        mem_addr = {elem_addr[WIDTH-1:2], 2'b00};
        for (int i = 0; i < NELEM; i++) begin
          if (idx == 3'(i)) mem_wdata = wd_q[i];
        end
        if (mem_ready && last_elem) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      is_store_q <= 1'b0;
      base_q     <= '0;
      n_q        <= '0;
      idx        <= '0;
      for (int i = 0; i < NELEM; i++) begin
        wd_q[i] <= '0;
        rd_q[i] <= '0;
      end
    end else begin
      state <= state_next;
      if (state == IDLE && start) begin
        is_store_q <= is_store;
        base_q     <= base_addr;
        n_q        <= n_in;
        idx        <= '0;
        for (int i = 0; i < NELEM; i++) begin
          wd_q[i] <= wd_in[i];
          if (!is_store) rd_q[i] <= '0;
        end
      end
      // idx parks on the last element so the address stays valid until DONE.
      if (xfer) begin
        for (int i = 0; i < NELEM; i++) begin
          if (!is_store_q && idx == 3'(i)) rd_q[i] <= mem_rdata;
        end
        if (!last_elem) idx <= idx + 3'd1;
      end
    end
  end

endmodule
